// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined ARM core: byte-addressed data memory with a fixed multi-cycle access latency.
// Optional build macro MEM_ACCESS_ALIGN_CHECK_EN enables misaligned-doubleword detection and suppression.
module mem_access_stage #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead_MEM,
    input  logic        memWrite_MEM,
    input  logic        xferByte_MEM,
    input  logic [63:0] address_MEM,
    input  logic [63:0] writeData_MEM,
    output logic [63:0] memDataOut,
    output logic        stall_MEM,
    output logic        misaligned_MEM
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        addr_r;
    logic [63:0]             wdata_r;
    logic                    byte_r;
    logic                    write_r;
    logic                    req_s;
    logic                    access_s;
    logic                    bad_s;
    logic [63:0]             rd_dword_s;
    logic [8*DEPTH_BYTES-1:0] mem_flat_s;
    logic                    unused_addr_s;

    // Byte index of a doubleword lane, wrapping inside the memory.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input logic [2:0] off);
        return base + IDX_W'(off);
    endfunction

    assign unused_addr_s = ^address_MEM[63:IDX_W];
    assign req_s         = memRead_MEM | memWrite_MEM;
    assign access_s      = (state_r == BUSY) && (cnt_r == CNT_ZERO);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic mis_r;

    assign bad_s = mis_r;

    // Misalignment flag is raised only for the DONE cycle following a misaligned access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned_MEM <= 1'b0;
        end else begin
            misaligned_MEM <= access_s & mis_r;
        end
    end

    // Capture whether the accepted request is a misaligned doubleword.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mis_r <= 1'b0;
        end else if ((state_r == IDLE) && req_s) begin
            mis_r <= ~xferByte_MEM & (address_MEM[2:0] != 3'b000);
        end
    end
`else
    assign bad_s          = 1'b0;
    assign misaligned_MEM = 1'b0;
`endif

    // Next-state and Mealy stall: the pipeline freezes in the same cycle a request appears.
    always_comb begin
        state_nxt_s = state_r;
        stall_MEM   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    stall_MEM   = 1'b1;
                    state_nxt_s = BUSY;
                end else begin
                    stall_MEM   = 1'b0;
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                stall_MEM = 1'b1;
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                stall_MEM   = 1'b0;
                state_nxt_s = IDLE;
            end
            default: begin
                stall_MEM   = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register, latency counter and request capture (inputs only sampled in IDLE).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            addr_r  <= {IDX_W{1'b0}};
            wdata_r <= 64'h0;
            byte_r  <= 1'b0;
            write_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == IDLE) && req_s) begin
                cnt_r   <= CNT_LOAD;
                addr_r  <= address_MEM[IDX_W-1:0];
                wdata_r <= writeData_MEM;
                byte_r  <= xferByte_MEM;
                write_r <= memWrite_MEM;
            end else if ((state_r == BUSY) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    // Little-endian doubleword gather; lanes wrap past the top of memory.
    always_comb begin
        rd_dword_s = 64'h0;
        for (int i = 0; i < 8; i++) begin
            rd_dword_s[8*i +: 8] = mem_flat_s[{wrap_idx(addr_r, 3'(i)), 3'b000} +: 8];
        end
    end

    // Load result register; stores and the idle path leave it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memDataOut <= 64'h0;
        end else if (access_s && !write_r) begin
            if (bad_s) begin
                memDataOut <= 64'h0;
            end else if (byte_r) begin
                memDataOut <= {56'h0, mem_flat_s[{addr_r, 3'b000} +: 8]};
            end else begin
                memDataOut <= rd_dword_s;
            end
        end
    end

    // One register per memory byte; each decides whether the current store covers it.
    for (genvar j = 0; j < DEPTH_BYTES; j++) begin : g_mem
        logic [IDX_W-1:0] off_s;
        logic             hit_s;
        logic [7:0]       cell_r;

        // Offset of this byte from the access base, modulo memory size.
        always_comb begin
            off_s = IDX_W'(j) - addr_r;
            if (byte_r) begin
                hit_s = (off_s == {IDX_W{1'b0}});
            end else begin
                hit_s = ({1'b0, off_s} < (IDX_W + 1)'(8));
            end
        end

        // Byte storage, cleared on reset.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cell_r <= 8'h00;
            end else if (access_s && write_r && !bad_s && hit_s) begin
                cell_r <= wdata_r[{off_s[2:0], 3'b000} +: 8];
            end
        end

        assign mem_flat_s[8*j +: 8] = cell_r;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table driven through a scoreboard, plus reset sequences.
module tb_mem_access_stage;

    localparam int DEPTH   = 1024;
    localparam int LAT     = 3;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    localparam bit ALIGN   = 1'b1;
`else
    localparam bit ALIGN   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memRead_MEM = 1'b0;
    logic        memWrite_MEM = 1'b0;
    logic        xferByte_MEM = 1'b0;
    logic [63:0] address_MEM = 64'h0;
    logic [63:0] writeData_MEM = 64'h0;
    logic [63:0] memDataOut;
    logic        stall_MEM;
    logic        misaligned_MEM;

    mem_access_stage #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .memRead_MEM(memRead_MEM),
        .memWrite_MEM(memWrite_MEM),
        .xferByte_MEM(xferByte_MEM),
        .address_MEM(address_MEM),
        .writeData_MEM(writeData_MEM),
        .memDataOut(memDataOut),
        .stall_MEM(stall_MEM),
        .misaligned_MEM(misaligned_MEM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        byt;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        mis;
        int          id;
    } sb_t;

    vec_t vecs [16];
    sb_t  sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic byt, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] exp_data, input logic exp_mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.byt = byt; v.addr = addr;
        v.wdata = wdata; v.exp_data = exp_data; v.exp_mis = exp_mis;
        return v;
    endfunction

    // Drive one request from IDLE, hold it through DONE, score the DONE cycle.
    task automatic apply_op(input vec_t v, input int id);
        sb_t e;
        sb_t got;
        int  stalls;
        int  cyc;
        memRead_MEM   = v.rd;
        memWrite_MEM  = v.wr;
        xferByte_MEM  = v.byt;
        address_MEM   = v.addr;
        writeData_MEM = v.wdata;
        e.data = v.exp_data;
        e.mis  = v.exp_mis;
        e.id   = id;
        sb_q.push_back(e);
        @(negedge clk);
        check($sformatf("op%0d mis_idle", id), {63'h0, misaligned_MEM}, 64'h0);
        stalls = 0;
        cyc    = 0;
        while (stall_MEM && cyc < 50) begin
            stalls++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL op%0d timeout: stall still high after %0d cycles", id, cyc);
        end
        got = sb_q.pop_front();
        check($sformatf("op%0d stall_cycles", got.id), 64'(stalls), 64'(LAT + 1));
        check($sformatf("op%0d data", got.id), memDataOut, got.data);
        check($sformatf("op%0d mis_done", got.id), {63'h0, misaligned_MEM}, {63'h0, got.mis});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Main-function vectors; misaligned entries depend on the alignment-check build.
        vecs[0]  = mk(1'b0, 1'b1, 1'b0, 64'd16, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 64'd16, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 64'd17, 64'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 64'd16, 64'h0, 64'h0123_4567_89AB_FFEF, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b1, 64'd17, 64'h0, 64'h0000_0000_0000_00FF, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 64'(DEPTH + 8), 64'h1122_3344_5566_7788, 64'hFF, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 64'd8, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 64'd100, 64'h5A, 64'h1122_3344_5566_7788, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 64'd100, 64'h0, 64'h5A, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 64'd3, 64'h0,
                      ALIGN ? 64'h0 : 64'h6677_8800_0000_0000, ALIGN);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 64'd3, 64'hCAFE_BABE_1234_5678,
                      ALIGN ? 64'h0 : 64'h6677_8800_0000_0000, ALIGN);
        vecs[11] = mk(1'b1, 1'b0, 1'b0, 64'd8, 64'h0,
                      ALIGN ? 64'h1122_3344_5566_7788 : 64'h1122_3344_55CA_FEBA, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 1'b0, 64'd0, 64'h0, 64'h0, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 64'd1020, 64'h0807_0605_0403_0201, 64'h0, ALIGN);
        vecs[14] = mk(1'b1, 1'b0, 1'b1, 64'd1, 64'h0, ALIGN ? 64'h0 : 64'h06, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, 1'b0, 64'd1020, 64'h0,
                      ALIGN ? 64'h0 : 64'h0807_0605_0403_0201, ALIGN);

        #2;
        check("reset_stall", {63'h0, stall_MEM}, 64'h0);
        check("reset_data", memDataOut, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("idle%0d_stall", c), {63'h0, stall_MEM}, 64'h0);
            check($sformatf("idle%0d_data", c), memDataOut, 64'h0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            apply_op(vecs[i], i);
        end

        // Reset in the second BUSY cycle of a store aborts it and clears the load register.
        memRead_MEM   = 1'b0;
        memWrite_MEM  = 1'b1;
        xferByte_MEM  = 1'b0;
        address_MEM   = 64'd0;
        writeData_MEM = 64'hAA;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midbusy_stall_before", {63'h0, stall_MEM}, 64'h1);
        reset        = 1'b1;
        memWrite_MEM = 1'b0;
        #1;
        check("midbusy_stall_after", {63'h0, stall_MEM}, 64'h0);
        check("midbusy_data_cleared", memDataOut, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 12; i < 16; i++) begin
            apply_op(vecs[i], i);
        end

        memRead_MEM  = 1'b0;
        memWrite_MEM = 1'b0;
        @(negedge clk);
        check("final_idle_stall", {63'h0, stall_MEM}, 64'h0);
        check("final_sb_empty", 64'(sb_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
